// File: rtl/quire_pkg.sv
// Shared sizing helpers for the posit quire family: operand widths, quire
// size, binary-point position and the channel index type.
package quire_pkg;

  localparam int CH_W_MAX = 8;

  // Wide enough to compare any channel number against NB_CHANNELS without
  // the comparison collapsing to a constant.
  typedef logic [CH_W_MAX-1:0] chan_idx_t;

  function automatic int get_fraction_width(input int n, input int es, input int prod);
    return (prod != 0) ? 2 * (n - es - 2) : (n - es - 3);
  endfunction

  function automatic int get_scale_width(input int n, input int es, input int prod);
    return es + $clog2(n) + 2 + ((prod != 0) ? 1 : 0);
  endfunction

  function automatic int get_nqmin(input int n, input int es);
    return (2 ** (es + 2)) * (n - 2) + 1;
  endfunction

  function automatic int get_quire_size(input int n, input int es, input int log_nb_accum);
    return get_nqmin(n, es) + log_nb_accum;
  endfunction

  // Quire bit weight of the fraction LSB when scale == 0.
  function automatic int get_bpp_lsb(input int n, input int es, input int prod);
    return (get_nqmin(n, es) - 1) / 2 - get_fraction_width(n, es, prod);
  endfunction

  function automatic int get_ch_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/quire_align.sv
// Combinational alignment of a decoded posit operand into quire format:
// hidden bit restored, shifted by the effective scale, then sign applied.
module quire_align #(
  parameter int FW  = 5,
  parameter int SW  = 5,
  parameter int QS  = 29,
  parameter int BPP = 7
) (
  input  logic [FW-1:0]        fraction,
  input  logic signed [SW-1:0] scale,
  input  logic                 sign,
  output logic [QS-1:0]        operand
);

  localparam int KW = 16;

  logic signed [KW-1:0] k;
  logic [KW-1:0]        amt;
  logic [QS-1:0]        h_ext;
  logic [QS-1:0]        mag;

  assign h_ext = QS'({1'b1, fraction});
  assign k     = KW'(BPP) + KW'(scale);
  assign amt   = k[KW-1] ? $unsigned(-k) : $unsigned(k);

  // Negative effective shift moves right and drops the bits below the quire LSB.
  assign mag     = k[KW-1] ? (h_ext >> amt) : (h_ext << amt);
  assign operand = sign ? -mag : mag;

endmodule

// File: rtl/quire_mc.sv
// Multi-channel posit quire accumulator: skid latch, S1 align, S2 per-channel
// read-modify-write. Define QUIRE_MC_OVF_EN to add the sticky ovf_o flag.
module quire_mc
  import quire_pkg::*;
#(
  parameter int  POSIT_WIDTH   = 16,
  parameter int  POSIT_ES      = 1,
  parameter int  LOG_NB_ACCUM  = 15,
  parameter int  IS_PROD_ACCUM = 0,
  parameter int  NB_CHANNELS   = 4,
  localparam int FW   = get_fraction_width(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM),
  localparam int SW   = get_scale_width(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM),
  localparam int QS   = get_quire_size(POSIT_WIDTH, POSIT_ES, LOG_NB_ACCUM),
  localparam int CH_W = get_ch_w(NB_CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 rtr_o,
  input  logic                 rts_i,
  input  logic                 sow_i,
  input  logic                 eow_i,
  input  logic [CH_W-1:0]      chan_i,
  input  logic [FW-1:0]        fraction,
  input  logic signed [SW-1:0] scale,
  input  logic                 sign_i,
  input  logic                 zero_i,
  input  logic                 NaR_i,
  input  logic                 rtr_i,
  output logic                 rts_o,
  output logic                 sow_o,
  output logic                 eow_o,
  output logic [CH_W-1:0]      chan_o,
  output logic [QS-1:0]        data_o,
  output logic                 NaR_o,
  output logic                 sign_o,
`ifdef QUIRE_MC_OVF_EN
  output logic                 ovf_o,
`endif
  output logic                 zero_o
);

  localparam int BPP = get_bpp_lsb(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM);

  // A beat moves when its sender asserts rts and the receiver's rtr is high in
  // the same cycle; rtr_o is registered, so a stall costs one skid entry.
  logic accept, process_en, in_v;

  logic                 skid_v, skid_sow, skid_eow, skid_sign, skid_zero, skid_nar;
  logic [CH_W-1:0]      skid_chan;
  logic [FW-1:0]        skid_frac;
  logic signed [SW-1:0] skid_scale;

  logic                 sel_sow, sel_eow, sel_sign, sel_zero, sel_nar;
  logic [CH_W-1:0]      sel_chan;
  logic [FW-1:0]        sel_frac;
  logic signed [SW-1:0] sel_scale;
  logic [QS-1:0]        aligned;

  logic            s1_v, s1_sow, s1_eow, s1_zero, s1_nar;
  logic [CH_W-1:0] s1_chan;
  logic [QS-1:0]   s1_op;

  logic [QS-1:0] quire [NB_CHANNELS];
  logic          nar   [NB_CHANNELS];

  logic            in_range;
  logic [CH_W-1:0] idx;
  logic [QS-1:0]   cur_q, sum, new_q, out_q;
  logic            cur_nar, new_nar, out_nar;

  assign accept     = rts_i & rtr_o;
  assign process_en = rtr_i | ~rts_o;
  assign in_v       = skid_v | accept;

  assign sel_sow   = skid_v ? skid_sow   : sow_i;
  assign sel_eow   = skid_v ? skid_eow   : eow_i;
  assign sel_sign  = skid_v ? skid_sign  : sign_i;
  assign sel_zero  = skid_v ? skid_zero  : zero_i;
  assign sel_nar   = skid_v ? skid_nar   : NaR_i;
  assign sel_chan  = skid_v ? skid_chan  : chan_i;
  assign sel_frac  = skid_v ? skid_frac  : fraction;
  assign sel_scale = skid_v ? skid_scale : scale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_o      <= 1'b0;
      skid_v     <= 1'b0;
      skid_sow   <= 1'b0;
      skid_eow   <= 1'b0;
      skid_sign  <= 1'b0;
      skid_zero  <= 1'b0;
      skid_nar   <= 1'b0;
      skid_chan  <= '0;
      skid_frac  <= '0;
      skid_scale <= '0;
    end else begin
      rtr_o <= process_en;
      if (accept && !process_en) begin
        skid_v     <= 1'b1;
        skid_sow   <= sow_i;
        skid_eow   <= eow_i;
        skid_sign  <= sign_i;
        skid_zero  <= zero_i;
        skid_nar   <= NaR_i;
        skid_chan  <= chan_i;
        skid_frac  <= fraction;
        skid_scale <= scale;
      end else if (process_en) begin
        skid_v <= 1'b0;
      end
    end
  end

  quire_align #(
    .FW (FW),
    .SW (SW),
    .QS (QS),
    .BPP(BPP)
  ) u_align (
    .fraction(sel_frac),
    .scale   (sel_scale),
    .sign    (sel_sign),
    .operand (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sow  <= 1'b0;
      s1_eow  <= 1'b0;
      s1_zero <= 1'b0;
      s1_nar  <= 1'b0;
      s1_chan <= '0;
      s1_op   <= '0;
    end else if (process_en) begin
      s1_v    <= in_v;
      s1_sow  <= sel_sow;
      s1_eow  <= sel_eow;
      s1_zero <= sel_zero;
      s1_nar  <= sel_nar;
      s1_chan <= sel_chan;
      s1_op   <= aligned;
    end
  end

  assign in_range = chan_idx_t'(s1_chan) < chan_idx_t'(NB_CHANNELS);
  assign idx      = in_range ? s1_chan : '0;
  assign cur_q    = quire[idx];
  assign cur_nar  = nar[idx];
  assign sum      = cur_q + s1_op;

  // NaR wins over everything; with sow it still clears the quire first.
  always_comb begin
    new_q   = cur_q;
    new_nar = cur_nar;
    if (s1_sow) begin
      new_nar = 1'b0;
      new_q   = s1_zero ? '0 : s1_op;
    end else if (!s1_zero) begin
      new_q = sum;
    end
    if (s1_nar) begin
      new_nar = 1'b1;
      new_q   = s1_sow ? '0 : cur_q;
    end
  end

  assign out_q   = in_range ? new_q : '0;
  assign out_nar = in_range ? new_nar : 1'b1;

`ifdef QUIRE_MC_OVF_EN
  logic ovf [NB_CHANNELS];
  logic new_ovf, out_ovf;

  always_comb begin
    new_ovf = ovf[idx];
    if (s1_sow) begin
      new_ovf = 1'b0;
    end else if (!s1_zero && !s1_nar &&
                 (cur_q[QS-1] == s1_op[QS-1]) && (sum[QS-1] != cur_q[QS-1])) begin
      new_ovf = 1'b1;
    end
  end

  assign out_ovf = in_range ? new_ovf : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_CHANNELS; i++) ovf[i] <= 1'b0;
      ovf_o <= 1'b0;
    end else if (process_en && s1_v) begin
      if (in_range) ovf[idx] <= new_ovf;
      ovf_o <= out_ovf;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_CHANNELS; i++) begin
        quire[i] <= '0;
        nar[i]   <= 1'b0;
      end
      rts_o  <= 1'b0;
      sow_o  <= 1'b0;
      eow_o  <= 1'b0;
      chan_o <= '0;
      data_o <= '0;
      NaR_o  <= 1'b0;
      sign_o <= 1'b0;
      zero_o <= 1'b0;
    end else if (process_en) begin
      rts_o <= s1_v;
      if (s1_v) begin
        if (in_range) begin
          quire[idx] <= new_q;
          nar[idx]   <= new_nar;
        end
        sow_o  <= s1_sow;
        eow_o  <= s1_eow;
        chan_o <= s1_chan;
        data_o <= out_q;
        NaR_o  <= out_nar;
        sign_o <= out_q[QS-1];
        zero_o <= (out_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_quire_mc.sv
// Randomized bench for quire_mc against a value-level model of the per-channel
// quires; covers QUIRE_MC_OVF_EN when that macro is defined.
module tb_quire_mc;

  localparam int NB  = 3;
  localparam int QS  = 29;
  localparam int FW  = 5;
  localparam int SW  = 5;
  localparam int BPP = 7;
  localparam int W   = 8 + QS;
  localparam longint MASK = (longint'(1) << QS) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic rtr_o, rts_i, sow_i, eow_i, sign_i, zero_i, NaR_i, rtr_i;
  logic [1:0] chan_i;
  logic [FW-1:0] fraction;
  logic signed [SW-1:0] scale;
  logic rts_o, sow_o, eow_o, NaR_o, sign_o, zero_o, ovf_v;
  logic [1:0] chan_o;
  logic [QS-1:0] data_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int bp_mode = 0;
  bit lat_chk = 0;

  logic [W-1:0] exp_q[$];
  int acc_q[$];

  longint m_q[NB];
  bit m_nar[NB];
  bit m_ovf[NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quire_mc #(
    .POSIT_WIDTH(8), .POSIT_ES(0), .LOG_NB_ACCUM(4), .IS_PROD_ACCUM(0), .NB_CHANNELS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
    .chan_i(chan_i), .fraction(fraction), .scale(scale), .sign_i(sign_i), .zero_i(zero_i),
    .NaR_i(NaR_i), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
    .chan_o(chan_o), .data_o(data_o), .NaR_o(NaR_o), .sign_o(sign_o),
`ifdef QUIRE_MC_OVF_EN
    .ovf_o(ovf_v),
`endif
    .zero_o(zero_o)
  );

`ifndef QUIRE_MC_OVF_EN
  assign ovf_v = 1'b0;
`endif

  // value = (1.fraction) * 2^scale, quire LSB weight 2^-(BPP+FW)
  function automatic longint operand_of(input int frac, input int scl, input bit sgn);
    longint h, m;
    int k;
    h = longint'(1 << FW) + longint'(frac);
    k = BPP + scl;
    if (k >= 0) m = h * (longint'(1) << k);
    else m = h / (longint'(1) << (-k));
    m = m & MASK;
    if (sgn) m = (-m) & MASK;
    return m;
  endfunction

  function automatic longint sval(input longint x);
    return (x >= (longint'(1) << (QS - 1))) ? x - (longint'(1) << QS) : x;
  endfunction

  function automatic logic [W-1:0] model_step(input int ch, input bit sow, input bit eow,
      input int frac, input int scl, input bit sgn, input bit zro, input bit nar);
    longint op, d, s;
    bit o_nar, o_ovf;
    op = operand_of(frac, scl, sgn);
    if (ch >= NB) begin
      d = 0; o_nar = 1; o_ovf = 0;
    end else begin
      if (sow) begin
        m_nar[ch] = 0;
        m_ovf[ch] = 0;
        m_q[ch] = zro ? 0 : op;
      end else if (!zro && !nar) begin
        s = sval(m_q[ch]) + sval(op);
        if (s < -(longint'(1) << (QS - 1)) || s >= (longint'(1) << (QS - 1))) m_ovf[ch] = 1;
        m_q[ch] = (m_q[ch] + op) & MASK;
      end
      if (nar) begin
        m_nar[ch] = 1;
        if (sow) m_q[ch] = 0;
      end
      d = m_q[ch]; o_nar = m_nar[ch]; o_ovf = m_ovf[ch];
    end
`ifndef QUIRE_MC_OVF_EN
    o_ovf = 0;
`endif
    return {2'(ch), sow, eow, o_nar, o_ovf, d[QS-1], (d == 0), QS'(d)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_q[i] = 0; m_nar[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int ch, input bit sow, input bit eow, input int frac,
      input int scl, input bit sgn, input bit zro, input bit nar);
    int budget;
    chan_i = 2'(ch); sow_i = sow; eow_i = eow; fraction = FW'(frac); scale = SW'(scl);
    sign_i = sgn; zero_i = zro; NaR_i = nar; rts_i = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (rtr_o) begin
        exp_q.push_back(model_step(ch, sow, eow, frac, scl, sgn, zro, nar));
        acc_q.push_back(cyc);
        break;
      end
      budget++;
      if (budget > 200) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: rtr_o stuck at %0b, required 1", rtr_o);
        break;
      end
    end
    @(posedge clk);
    #1;
    rts_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    bp_mode = 0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; chan_i = '0; fraction = '0;
    scale = '0; sign_i = 1'b0; zero_i = 1'b0; NaR_i = 1'b0; rtr_i = 1'b1;
    model_clear();

    fork
      begin : monitor
        logic [W-1:0] exp_w, act_w;
        bit prev_pe, have_prev;
        int a;
        have_prev = 0;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (have_prev) check("rtr_o_follow", {63'd0, rtr_o}, {63'd0, prev_pe});
            if (rts_o && rtr_i) begin
              act_w = {chan_o, sow_o, eow_o, NaR_o, ovf_v, sign_o, zero_o, data_o};
              if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_beat: got %0h, required no output", act_w);
              end else begin
                exp_w = exp_q.pop_front();
                a = acc_q.pop_front();
                check("out_beat", 64'(act_w), 64'(exp_w));
                if (lat_chk) check("latency", 64'(cyc - a), 64'd2);
              end
            end
          end
          prev_pe = rtr_i | ~rts_o;
          have_prev = rst_n;
        end
      end
      begin : backpressure
        forever begin
          @(posedge clk);
          #1;
          case (bp_mode)
            1:       rtr_i = ($urandom_range(0, 3) != 0);
            2:       rtr_i = 1'b0;
            default: rtr_i = 1'b1;
          endcase
        end
      end
    join_none

    // Hand-derived operand values pin the model's alignment rule.
    check("pin_one",      64'(operand_of(0, 0, 0)),   64'd4096);
    check("pin_0p75",     64'(operand_of(16, -1, 0)), 64'd3072);
    check("pin_rshift1",  64'(operand_of(0, -8, 0)),  64'd16);
    check("pin_rshift5",  64'(operand_of(0, -12, 0)), 64'd1);
    check("pin_neg_one",  64'(operand_of(0, 0, 1)),   64'd536866816);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rts_o",  {63'd0, rts_o},  64'd0);
    check("rst_rtr_o",  {63'd0, rtr_o},  64'd0);
    check("rst_data_o", 64'(data_o),     64'd0);
    check("rst_nar_o",  {63'd0, NaR_o},  64'd0);
    check("rst_zero_o", {63'd0, zero_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    lat_chk = 1;
    send(0, 1, 0, 0, 0, 0, 0, 0);
    send(0, 0, 1, 0, 0, 0, 0, 0);
    drain();
    lat_chk = 0;
    check("pin_t1", 64'(m_q[0]), 64'd8192);

    send(0, 1, 0, 0, 0, 0, 0, 0);
    send(1, 1, 0, 16, -1, 0, 0, 0);
    send(0, 0, 0, 0, 0, 0, 0, 0);
    send(1, 0, 1, 0, 0, 1, 0, 0);
    drain();
    check("pin_t2_ch1", 64'(m_q[1]), 64'd536869888);

    send(0, 1, 0, 0, -8, 0, 0, 0);
    send(0, 0, 1, 0, -12, 0, 0, 0);
    drain();
    check("pin_t3", 64'(m_q[0]), 64'd17);

    send(1, 1, 0, 0, 0, 0, 0, 0);
    send(1, 0, 0, 5, 2, 0, 0, 1);
    send(1, 0, 0, 0, 0, 0, 0, 0);
    send(0, 1, 0, 0, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0, 0, 0, 0);
    send(1, 1, 0, 0, 1, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0, 0, 1);
    send(1, 0, 0, 16, 0, 0, 0, 0);
    send(0, 0, 0, 7, 3, 0, 1, 0);
    send(0, 1, 0, 7, 3, 0, 1, 0);
    send(3, 1, 0, 9, 2, 0, 0, 0);
    send(0, 0, 1, 0, 0, 0, 0, 0);
    drain();
    check("pin_t4_nar", {63'd0, m_nar[1]}, 64'd1);

    fork
      begin
        send(2, 1, 0, 0, 0, 0, 0, 0);
        send(2, 0, 0, 16, -1, 0, 0, 0);
        send(2, 0, 0, 0, 2, 0, 0, 0);
        send(2, 0, 1, 3, -4, 1, 0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        bp_mode = 2;
        repeat (5) @(posedge clk);
        bp_mode = 0;
      end
    join
    drain();

    send(0, 1, 0, 0, 15, 0, 0, 0);
    send(0, 0, 0, 0, 15, 0, 0, 0);
    send(0, 0, 0, 0, -8, 0, 0, 0);
    send(0, 1, 1, 0, 0, 0, 0, 0);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, NB - 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)) - 16,
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    drain();

    // Asynchronous reset in the middle of a cycle wipes every channel.
    send(1, 0, 0, 0, 0, 0, 0, 1);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rts_o",  {63'd0, rts_o}, 64'd0);
    check("arst_rtr_o",  {63'd0, rtr_o}, 64'd0);
    check("arst_data_o", 64'(data_o),    64'd0);
    check("arst_nar_o",  {63'd0, NaR_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    send(0, 0, 0, 0, 0, 0, 0, 0);
    send(1, 0, 1, 0, 0, 0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
